// File: rtl/jtgng_objlinescan_if.sv
// Signal bundle between the per-line object scanner and its surroundings
// (line timing, sprite RAM copy, draw-stage reader).
// No valid/ready pairs here: cen6 qualifies every transfer. An address on
// pre_scan gets its data on ram_dout one cen6 step later. An objcnt/objbyte
// index gets its data on objbuf_data one cen6 step later.
interface jtgng_objlinescan_if #(
    parameter int OBJAW = 7,
    parameter int BYTEW = 2,
    parameter int LINEW = 5
);
    logic                   cen6;
    logic                   HINIT;
    logic                   LVBL;
    logic [7:0]             V;
    logic                   flip;
    logic [OBJAW+BYTEW-1:0] pre_scan;
    logic [7:0]             ram_dout;
    logic [LINEW-1:0]       objcnt;
    logic [BYTEW-1:0]       objbyte;
    logic [7:0]             objbuf_data;
    logic [7:0]             VF;
    logic                   line;
    logic [LINEW:0]         entries;
    logic                   overflow;
    logic                   busy;
    logic [2:0]             dbg_state;

    modport master (
        input  cen6, HINIT, LVBL, V, flip, ram_dout, objcnt, objbyte,
        output pre_scan, objbuf_data, VF, line, entries, overflow, busy, dbg_state
    );

    modport slave (
        output cen6, HINIT, LVBL, V, flip, ram_dout, objcnt, objbyte,
        input  pre_scan, objbuf_data, VF, line, entries, overflow, busy, dbg_state
    );
endinterface

// File: rtl/jtgng_objlinescan.sv
// Per-line object scanner: selects sprites covering the next line into a double-buffered list.
// Optional JTOBJSCAN_REVERSE_EN scans from the highest object number down to 0.
module jtgng_objlinescan #(
    parameter int OBJAW = 7,
    parameter int BYTEW = 2,
    parameter int YOFF  = 2,
    parameter int LINEW = 5,
    parameter int SPRH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    jtgng_objlinescan_if.master  bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDY  = 3'd1,
        ST_CHK  = 3'd2,
        ST_CPY  = 3'd3,
        ST_NXT  = 3'd4
    } state_t;

    localparam int              LISTW    = LINEW + BYTEW;
    localparam logic [BYTEW-1:0] YOFF_B  = BYTEW'(YOFF);
    localparam logic [8:0]       SPRH_W  = 9'(SPRH);
    localparam logic [BYTEW:0]   CPY_LAST = {1'b1, {BYTEW{1'b0}}};
`ifdef JTOBJSCAN_REVERSE_EN
    localparam logic [OBJAW-1:0] OBJ_FIRST = {OBJAW{1'b1}};
    localparam logic [OBJAW-1:0] OBJ_LAST  = {OBJAW{1'b0}};
    localparam logic [OBJAW-1:0] OBJ_STEP  = {OBJAW{1'b1}};
`else
    localparam logic [OBJAW-1:0] OBJ_FIRST = {OBJAW{1'b0}};
    localparam logic [OBJAW-1:0] OBJ_LAST  = {OBJAW{1'b1}};
    localparam logic [OBJAW-1:0] OBJ_STEP  = {{(OBJAW-1){1'b0}}, 1'b1};
`endif

    state_t           state_q, state_d;
    logic [OBJAW-1:0] obj_q, obj_d;
    logic [BYTEW:0]   cpy_q, cpy_d;
    logic [LINEW:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             line_q, line_d;
    logic [LINEW:0]   entries_q, entries_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       vf_q, vf_d;
    logic [7:0]       data_q, data_d;

    logic [7:0]             buf_mem [0:1][0:(2**LISTW)-1];
    logic                   wr_en;
    logic [LISTW-1:0]       wr_addr;
    logic [LISTW-1:0]       rd_addr;
    logic [OBJAW+BYTEW-1:0] pre_scan;
    logic [7:0]             dy;
    logic                   hit;

    always_comb begin
        state_d    = state_q;
        obj_d      = obj_q;
        cpy_d      = cpy_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        line_d     = line_q;
        entries_d  = entries_q;
        overflow_d = overflow_q;
        vf_d       = vf_q;
        data_d     = data_q;
        wr_en      = 1'b0;
        pre_scan   = '0;
        dy         = vf_q - bus.ram_dout;
        hit        = {1'b0, dy} < SPRH_W;
        wr_addr    = {cnt_q[LINEW-1:0], cpy_q[BYTEW-1:0] - BYTEW'(1)};
        rd_addr    = {bus.objcnt, bus.objbyte};

        unique case (state_q)
            ST_RDY:  pre_scan = {obj_q, YOFF_B};
            ST_CPY:  pre_scan = {obj_q, cpy_q[BYTEW-1:0]};
            default: pre_scan = '0;
        endcase

        if (bus.cen6) begin
            // HINIT swaps banks and abandons whatever the scan was doing;
            // a half-copied record is simply never counted.
            if (bus.HINIT) begin
                line_d     = ~line_q;
                entries_d  = cnt_q;
                overflow_d = ovf_q;
                cnt_d      = '0;
                ovf_d      = 1'b0;
                vf_d       = (bus.V + 8'd1) ^ {8{bus.flip}};
                obj_d      = OBJ_FIRST;
                state_d    = bus.LVBL ? ST_RDY : ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: state_d = ST_IDLE;
                    ST_RDY:  state_d = ST_CHK;
                    ST_CHK: begin
                        if (!hit) begin
                            state_d = ST_NXT;
                        end else if (!cnt_q[LINEW]) begin
                            cpy_d   = '0;
                            state_d = ST_CPY;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_CPY: begin
                        // Data lags the address by one step, so byte n lands on step n+1.
                        wr_en = (cpy_q != '0);
                        if (cpy_q == CPY_LAST) begin
                            cnt_d   = cnt_q + (LINEW+1)'(1);
                            state_d = ST_NXT;
                        end else begin
                            cpy_d = cpy_q + (BYTEW+1)'(1);
                        end
                    end
                    ST_NXT: begin
                        if (obj_q == OBJ_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            obj_d   = obj_q + OBJ_STEP;
                            state_d = ST_RDY;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            data_d = ({1'b0, bus.objcnt} >= entries_q) ? 8'hF8 : buf_mem[line_q][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            obj_q      <= '0;
            cpy_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            line_q     <= 1'b0;
            entries_q  <= '0;
            overflow_q <= 1'b0;
            vf_q       <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            obj_q      <= obj_d;
            cpy_q      <= cpy_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            line_q     <= line_d;
            entries_q  <= entries_d;
            overflow_q <= overflow_d;
            vf_q       <= vf_d;
            data_q     <= data_d;
        end
    end

    // The write bank is always the one the draw side is not reading.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            buf_mem[~line_q][wr_addr] <= bus.ram_dout;
        end
    end

    assign bus.pre_scan    = pre_scan;
    assign bus.objbuf_data = data_q;
    assign bus.VF          = vf_q;
    assign bus.line        = line_q;
    assign bus.entries     = entries_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_jtgng_objlinescan.sv
// Bench for jtgng_objlinescan: sprite RAM model, line driver, list reference model and scoreboard.
module tb_jtgng_objlinescan;
    localparam int OBJAW = 7;
    localparam int BYTEW = 2;
    localparam int LINEW = 5;
    localparam int NOBJ  = 128;
    localparam int NREC  = 4;
    localparam int NSLOT = 32;
    localparam int NREAD = NSLOT * NREC;
    localparam int ST_IDLE = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtgng_objlinescan_if #(.OBJAW(OBJAW), .BYTEW(BYTEW), .LINEW(LINEW)) bus();

    jtgng_objlinescan #(
        .OBJAW(OBJAW), .BYTEW(BYTEW), .YOFF(2), .LINEW(LINEW), .SPRH(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock enable at half the clock rate
    initial bus.cen6 = 1'b0;
    always @(posedge clk) bus.cen6 <= ~bus.cen6;

    logic [7:0] spr [NOBJ*NREC];
    initial bus.ram_dout = 8'h00;
    always @(posedge clk) if (bus.cen6) bus.ram_dout <= spr[bus.pre_scan];

    logic [7:0] exp_q[$];
    int         exp_entries;
    bit         exp_ovf;
    bit         exp_line;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cen_step();
        do @(negedge clk); while (!bus.cen6);
    endtask

    task automatic set_empty_exp();
        exp_entries = 0;
        exp_ovf     = 1'b0;
        exp_q.delete();
        repeat (NREAD) exp_q.push_back(8'hF8);
    endtask

    task automatic fill_spr(input logic [7:0] yval);
        for (int i = 0; i < NOBJ*NREC; i++) spr[i] = 8'($urandom);
        for (int o = 0; o < NOBJ; o++) spr[o*NREC+2] = yval;
    endtask

    // Reference: walk objects in scan order, charging 3 steps per miss and
    // 8 per hit; a hit counts only if its copy finishes before the next HINIT.
    task automatic model(input logic [7:0] v, input bit fl, input bit lv, input int period);
        logic [7:0] vf;
        logic [7:0] dy;
        int         list[$];
        int         pos;
        int         o;
        bit         ovf;
        vf  = (v + 8'd1) ^ {8{fl}};
        pos = 1;
        ovf = 1'b0;
        if (lv) begin
            for (int i = 0; i < NOBJ; i++) begin
`ifdef JTOBJSCAN_REVERSE_EN
                o = NOBJ - 1 - i;
`else
                o = i;
`endif
                if (pos + 1 > period - 1) break;
                dy = vf - spr[o*NREC+2];
                if (dy < 8'd16) begin
                    if (list.size() == NSLOT) begin
                        ovf = 1'b1;
                        break;
                    end
                    if (pos + 6 > period - 1) break;
                    list.push_back(o);
                    pos += 8;
                end else begin
                    pos += 3;
                end
            end
        end
        exp_entries = list.size();
        exp_ovf     = ovf;
        exp_q.delete();
        for (int s = 0; s < NSLOT; s++)
            for (int b = 0; b < NREC; b++)
                exp_q.push_back((s < list.size()) ? spr[list[s]*NREC+b] : 8'hF8);
    endtask

    // One line: HINIT, check the bank that just became readable, then
    // compute what this line's scan should leave behind.
    task automatic run_line(input logic [7:0] v, input bit fl, input bit lv, input int period);
        logic [7:0] vfx;
        logic [7:0] e;
        vfx = (v + 8'd1) ^ {8{fl}};
        bus.V     = v;
        bus.flip  = fl;
        bus.LVBL  = lv;
        bus.HINIT = 1'b1;
        cen_step();
        bus.HINIT = 1'b0;
        exp_line  = ~exp_line;
        check("line", bus.line, exp_line);
        check("entries", bus.entries, exp_entries);
        check("overflow", bus.overflow, exp_ovf);
        check("vf", bus.VF, vfx);
        check("busy", bus.busy, lv);
        for (int k = 0; k < NREAD; k++) begin
            bus.objcnt  = LINEW'(k / NREC);
            bus.objbyte = BYTEW'(k % NREC);
            cen_step();
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hF8;
            check($sformatf("objbuf[%0d.%0d]", k / NREC, k % NREC), bus.objbuf_data, e);
        end
        repeat (period - 1 - NREAD) cen_step();
        model(v, fl, lv, period);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pre_scan"}, bus.pre_scan, 0);
        check({tag, ".vf"}, bus.VF, 0);
        check({tag, ".line"}, bus.line, 0);
        check({tag, ".entries"}, bus.entries, 0);
        check({tag, ".overflow"}, bus.overflow, 0);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".objbuf_data"}, bus.objbuf_data, 0);
        check({tag, ".state"}, bus.dbg_state, ST_IDLE);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] vf;
        bit         fl;
        bit         lv;
        rst         = 1'b1;
        bus.HINIT   = 1'b0;
        bus.LVBL    = 1'b0;
        bus.V       = 8'h00;
        bus.flip    = 1'b0;
        bus.objcnt  = '0;
        bus.objbyte = '0;
        fill_spr(8'h00);
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        cen_step();
        set_empty_exp();
        exp_line = 1'b0;

        // single hit: obj5 on line 0x11
        fill_spr(8'h00);
        spr[5*NREC+2] = 8'h10;
        run_line(8'h10, 1'b0, 1'b1, 600);

        // 40 hits: list fills, overflow reported
        fill_spr(8'h80);
        for (int o = 0; o < 40; o++) spr[o*NREC+2] = 8'h20;
        run_line(8'h20, 1'b0, 1'b1, 600);

        // flip: VF = 0xEE
        fill_spr(8'h80);
        spr[10*NREC+2] = 8'hE0;
        spr[11*NREC+2] = 8'h10;
        run_line(8'h10, 1'b1, 1'b1, 600);

        // wrap-around at Y=0xF8
        fill_spr(8'h80);
        spr[3*NREC+2] = 8'hF8;
        run_line(8'h02, 1'b0, 1'b1, 600);
        run_line(8'h07, 1'b0, 1'b1, 600);

        for (int n = 0; n < 10; n++) begin
            v  = 8'($urandom);
            fl = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 7) != 0);
            vf = (v + 8'd1) ^ {8{fl}};
            fill_spr(8'h00);
            for (int o = 0; o < NOBJ; o++)
                if ($urandom_range(0, 1) == 1) spr[o*NREC+2] = vf - 8'($urandom_range(0, 20));
            run_line(v, fl, lv, 600);
        end

        // short lines with every object hitting: scans get cut off
        fill_spr(8'h20);
        repeat (3) run_line(8'h20, 1'b0, 1'b1, 200);

        // vertical blank line, then a normal line
        run_line(8'h20, 1'b0, 1'b0, 600);
        run_line(8'h20, 1'b0, 1'b1, 600);

        // reset in the middle of a record copy
        bus.V     = 8'h20;
        bus.flip  = 1'b0;
        bus.LVBL  = 1'b1;
        bus.HINIT = 1'b1;
        cen_step();
        bus.HINIT = 1'b0;
        repeat (3) cen_step();
        check("busy_in_cpy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_cpy");
        rst = 1'b0;
        cen_step();
        set_empty_exp();
        exp_line = 1'b0;
        run_line(8'h20, 1'b0, 1'b1, 600);
        run_line(8'h20, 1'b0, 1'b1, 600);

        // reset and HINIT on the same step
        bus.V     = 8'h55;
        bus.LVBL  = 1'b1;
        bus.HINIT = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        check_all_zero("rst_hinit");
        bus.HINIT = 1'b0;
        rst       = 1'b0;
        cen_step();
        set_empty_exp();
        exp_line = 1'b0;
        run_line(8'h40, 1'b0, 1'b1, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
